// File: rtl/mcs4_pkg.sv
// Shared MCS-4 timing definitions: subcycle codes, clock generator FSM states
// and the nested slot/quarter/subcycle step used by the clock generator.
package mcs4_pkg;

  typedef logic [2:0] subcycle_t;

  localparam subcycle_t SUB_A1 = 3'd0;
  localparam subcycle_t SUB_A2 = 3'd1;
  localparam subcycle_t SUB_A3 = 3'd2;
  localparam subcycle_t SUB_M1 = 3'd3;
  localparam subcycle_t SUB_M2 = 3'd4;
  localparam subcycle_t SUB_X1 = 3'd5;
  localparam subcycle_t SUB_X2 = 3'd6;
  localparam subcycle_t SUB_X3 = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] Q_CLK1 = 2'd0;
  localparam logic [1:0] Q_CLK2 = 2'd2;
  localparam logic [1:0] Q_LAST = 2'd3;

  typedef struct packed {
    logic [7:0] slot;
    logic [1:0] quarter;
    subcycle_t  subcycle;
  } phase_t;

  // One sysclk step of the nested count; quarter and subcycle wrap by overflow.
  function automatic phase_t phase_step(input phase_t cur, input logic [7:0] last_slot);
    phase_t nxt;
    nxt = cur;
    if (cur.slot == last_slot) begin
      nxt.slot    = 8'd0;
      nxt.quarter = cur.quarter + 2'd1;
      if (cur.quarter == Q_LAST) begin
        nxt.subcycle = cur.subcycle + 3'd1;
      end
    end else begin
      nxt.slot = cur.slot + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/i4004_clkgen_if.sv
// Clock generator output bundle; master is the generator, slave a consumer
// that supplies the run enable.
interface i4004_clkgen_if;
  import mcs4_pkg::*;

  logic      run;
  logic      clk1;
  logic      clk2;
  logic      sync;
  logic      poc;
  subcycle_t subcycle;
  logic      cycle_start;

  modport master (
    input  run,
    output clk1, clk2, sync, poc, subcycle, cycle_start
  );

  modport slave (
    output run,
    input  clk1, clk2, sync, poc, subcycle, cycle_start
  );
endinterface

// File: rtl/i4004_phase_ctr.sv
// Nested slot/quarter/subcycle counter; wrap flags the last sysclk of X3.
module i4004_phase_ctr
  import mcs4_pkg::*;
#(
  parameter int SLOT_LEN = 4
) (
  input  logic       clk,
  input  logic       enable,
  input  logic       clear,
  output logic [7:0] slot,
  output logic [1:0] quarter,
  output subcycle_t  subcycle,
  output logic       wrap
);

  localparam logic [7:0] LAST_SLOT = 8'(SLOT_LEN - 1);

  phase_t ph_q, ph_d;

  always_comb begin
    ph_d = ph_q;
    if (clear) begin
      ph_d = '0;
    end else if (enable) begin
      ph_d = phase_step(ph_q, LAST_SLOT);
    end
  end

  always_ff @(posedge clk) begin
    ph_q <= ph_d;
  end

  assign slot     = ph_q.slot;
  assign quarter  = ph_q.quarter;
  assign subcycle = ph_q.subcycle;
  assign wrap     = (ph_q.slot == LAST_SLOT) && (ph_q.quarter == Q_LAST) &&
                    (ph_q.subcycle == SUB_X3);

endmodule

// File: rtl/i4004_clkgen.sv
// MCS-4 two-phase clock, sync and power-on-clear generator. All outputs come
// from flops loaded with the decode of the counters' next state.
module i4004_clkgen
  import mcs4_pkg::*;
#(
  parameter int SLOT_LEN   = 4,
  parameter int POC_CYCLES = 4
) (
  input  logic           sysclk,
  input  logic           poc_n,
  i4004_clkgen_if.master bus
);

  localparam logic [7:0] LAST_SLOT = 8'(SLOT_LEN - 1);
  localparam logic [3:0] POC_INIT  = 4'(POC_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] poc_cnt_q, poc_cnt_d;
  logic       clk1_q, clk1_d;
  logic       clk2_q, clk2_d;
  logic       sync_q, sync_d;
  logic       cs_q, cs_d;
  logic       poc_q, poc_d;

  logic       ctr_en, ctr_clr, wrap, run_nxt;
  logic [7:0] slot;
  logic [1:0] quarter;
  subcycle_t  subcycle;
  phase_t     ph_cur, ph_nxt;

  i4004_phase_ctr #(.SLOT_LEN(SLOT_LEN)) u_phase (
    .clk      (sysclk),
    .enable   (ctr_en),
    .clear    (ctr_clr),
    .slot     (slot),
    .quarter  (quarter),
    .subcycle (subcycle),
    .wrap     (wrap)
  );

  // run is only looked at in IDLE and on the X3 wrap, so mid-cycle changes are ignored.
  always_comb begin
    state_d   = state_q;
    ctr_en    = 1'b0;
    ctr_clr   = 1'b0;
    poc_cnt_d = poc_cnt_q;
    if (!poc_n) begin
      state_d   = ST_IDLE;
      ctr_clr   = 1'b1;
      poc_cnt_d = POC_INIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.run) state_d = ST_RUN;
        end
        ST_RUN: begin
          ctr_en = 1'b1;
          if (wrap) begin
            if (poc_cnt_q != 4'd0) poc_cnt_d = poc_cnt_q - 4'd1;
            if (!bus.run) begin
              state_d = ST_IDLE;
              ctr_clr = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ph_cur = '{slot: slot, quarter: quarter, subcycle: subcycle};
    ph_nxt = ph_cur;
    if (ctr_clr) begin
      ph_nxt = '0;
    end else if (ctr_en) begin
      ph_nxt = phase_step(ph_cur, LAST_SLOT);
    end
    run_nxt = (state_d == ST_RUN);
    clk1_d  = run_nxt && (ph_nxt.quarter == Q_CLK1);
    clk2_d  = run_nxt && (ph_nxt.quarter == Q_CLK2);
    sync_d  = run_nxt && (ph_nxt.subcycle == SUB_X3);
    cs_d    = run_nxt && (ph_nxt.slot == 8'd0) && (ph_nxt.quarter == Q_CLK1) &&
              (ph_nxt.subcycle == SUB_A1);
    poc_d   = (poc_cnt_d != 4'd0);
  end

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      state_q   <= ST_IDLE;
      poc_cnt_q <= POC_INIT;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
      sync_q    <= 1'b0;
      cs_q      <= 1'b0;
      poc_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      poc_cnt_q <= poc_cnt_d;
      clk1_q    <= clk1_d;
      clk2_q    <= clk2_d;
      sync_q    <= sync_d;
      cs_q      <= cs_d;
      poc_q     <= poc_d;
    end
  end

  assign bus.clk1        = clk1_q;
  assign bus.clk2        = clk2_q;
  assign bus.sync        = sync_q;
  assign bus.poc         = poc_q;
  assign bus.cycle_start = cs_q;
  assign bus.subcycle    = subcycle;

endmodule

// File: tb/tb_i4004_clkgen.sv
// Bench for i4004_clkgen: default and SLOT_LEN=2 instances share inputs and
// are compared every cycle against a position-in-cycle reference model.
module tb_i4004_clkgen;

  logic sysclk = 1'b0;
  logic poc_n;
  logic run_r;

  i4004_clkgen_if if1();
  i4004_clkgen_if if2();
  assign if1.run = run_r;
  assign if2.run = run_r;

  i4004_clkgen #(.SLOT_LEN(4), .POC_CYCLES(4)) dut (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (if1)
  );

  i4004_clkgen #(.SLOT_LEN(2), .POC_CYCLES(4)) dut2 (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (if2)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: running flag, sysclk position inside the instruction cycle, poc count.
  typedef struct {
    bit running;
    int p;
    int pcnt;
  } mdl_t;

  function automatic mdl_t mdl_next(mdl_t m, int L, bit rst_n, bit rn);
    mdl_t n;
    n = m;
    if (!rst_n) begin
      n.running = 1'b0;
      n.p       = 0;
      n.pcnt    = 4;
    end else if (!m.running) begin
      if (rn) begin
        n.running = 1'b1;
        n.p       = 0;
      end
    end else if (m.p == 32 * L - 1) begin
      if (m.pcnt > 0) n.pcnt = m.pcnt - 1;
      n.p       = 0;
      n.running = rn;
    end else begin
      n.p = m.p + 1;
    end
    return n;
  endfunction

  // {poc, cycle_start, sync, clk2, clk1, subcycle[2:0]}
  function automatic logic [7:0] mdl_out(mdl_t m, int L);
    int q, sc;
    logic [7:0] o;
    q = (m.p / L) % 4;
    sc = m.p / (4 * L);
    o = '0;
    o[7] = (m.pcnt != 0);
    if (m.running) begin
      o[6]   = (m.p == 0);
      o[5]   = (sc == 7);
      o[4]   = (q == 2);
      o[3]   = (q == 0);
      o[2:0] = 3'(sc);
    end
    return o;
  endfunction

  logic [7:0] out1, out2;
  assign out1 = {if1.poc, if1.cycle_start, if1.sync, if1.clk2, if1.clk1, if1.subcycle};
  assign out2 = {if2.poc, if2.cycle_start, if2.sync, if2.clk2, if2.clk1, if2.subcycle};

  mdl_t m1, m2;
  bit chk_en = 1'b0;

  initial begin
    m1 = '{running: 1'b0, p: 0, pcnt: 4};
    m2 = '{running: 1'b0, p: 0, pcnt: 4};
  end

  always @(posedge sysclk) begin
    m1 = mdl_next(m1, 4, poc_n, run_r);
    m2 = mdl_next(m2, 2, poc_n, run_r);
  end

  always @(negedge sysclk) begin
    if (chk_en) begin
      chk("model_L4", 32'(out1), 32'(mdl_out(m1, 4)));
      chk("model_L2", 32'(out2), 32'(mdl_out(m2, 2)));
      chk("no_overlap_L2", 32'(if2.clk1 & if2.clk2), 32'd0);
      no_overlap: assert (!(if2.clk1 && if2.clk2))
        else $error("FAIL overlap_assert: clk1 and clk2 both high (L2)");
    end
  end

  // Samples negedges after a cycle_start until the next one on the default instance.
  task automatic sample_cycle(output int len, output int sync_first, output int sync_cnt,
                              output int c1, output int c2, output int d2cs,
                              output logic sync_end);
    len = 0; sync_first = -1; sync_cnt = 0; c1 = 0; c2 = 0; d2cs = -1; sync_end = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge sysclk);
      if (if1.sync) begin
        sync_cnt++;
        if (sync_first < 0) sync_first = k;
      end
      if (if1.clk1) c1++;
      if (if1.clk2) c2++;
      if (if2.cycle_start && d2cs < 0) d2cs = k;
      if (if1.cycle_start) begin
        len = k;
        sync_end = if1.sync;
        break;
      end
    end
  endtask

  task automatic poc_sequence(input string tag, input bit detail);
    int len, sf, sn, c1, c2, d2;
    logic se;
    for (int n = 2; n <= 5; n++) begin
      sample_cycle(len, sf, sn, c1, c2, d2, se);
      chk({tag, "_cs_period"}, 32'(len), 32'd128);
      if (detail && n == 2) begin
        chk("sync_rise_offset", 32'(sf), 32'd112);
        chk("sync_width", 32'(sn), 32'd16);
        chk("sync_fall_at_cs", 32'(se), 32'd0);
        chk("clk1_high_count", 32'(c1), 32'd32);
        chk("clk2_high_count", 32'(c2), 32'd32);
        chk("l2_cycle_len", 32'(d2), 32'd64);
      end
      chk({tag, "_poc_at_cs"}, 32'(if1.poc), 32'(n < 5));
    end
  endtask

  initial begin
    bit found;
    bit seen_x3;
    poc_n = 1'b0;
    run_r = 1'b0;
    repeat (4) @(negedge sysclk);
    chk_en = 1'b1;
    chk("reset_state", 32'(out1), 32'h80);
    chk("reset_state_L2", 32'(out2), 32'h80);

    run_r = 1'b1;
    poc_n = 1'b1;
    @(negedge sysclk);
    chk("start_edge", 32'({if1.clk1, if1.cycle_start, if1.subcycle}), 32'b11000);
    poc_sequence("first", 1'b1);

    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sysclk);
      if (if1.subcycle == 3'd3) begin found = 1'b1; break; end
    end
    chk("reach_m1", 32'(found), 32'd1);
    run_r = 1'b0;
    seen_x3 = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sysclk);
      if (if1.sync) seen_x3 = 1'b1;
      else if (seen_x3) break;
    end
    chk("x3_completed", 32'(seen_x3), 32'd1);
    chk("idle_outputs", 32'(out1), 32'h00);
    repeat (10) @(negedge sysclk);
    chk("idle_hold", 32'(out1), 32'h00);
    run_r = 1'b1;
    @(negedge sysclk);
    chk("restart_edge", 32'({if1.cycle_start, if1.clk1, if1.subcycle}), 32'b11000);

    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sysclk);
      if (if1.subcycle == 3'd5 && if1.clk2) begin found = 1'b1; break; end
    end
    chk("reach_x1_clk2", 32'(found), 32'd1);
    poc_n = 1'b0;
    @(negedge sysclk);
    chk("reset_mid_clk2", 32'(out1), 32'h80);
    chk("reset_mid_clk2_L2", 32'(out2), 32'h80);
    poc_n = 1'b1;
    @(negedge sysclk);
    chk("restart_after_reset", 32'({if1.clk1, if1.cycle_start, if1.subcycle}), 32'b11000);
    poc_sequence("again", 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge sysclk);
      if ($urandom_range(0, 59) == 0) run_r = ~run_r;
      poc_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    poc_n = 1'b1;
    @(negedge sysclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i4004_clkgen.md
I4004_CLKGEN -- requirements
Module: i4004_clkgen

Interface
REQ-001 SHALL have parameter SLOT_LEN, default 4: sysclk cycles per clock quarter; legal range 2..255.
REQ-002 SHALL have parameter POC_CYCLES, default 4: complete instruction cycles that poc stays high after reset; legal range 1..15.
REQ-003 SHALL have port sysclk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port poc_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port run  input  1  run enable; sampled only at instruction-cycle boundaries and in IDLE.
REQ-006 SHALL have port clk1  output  1  MCS-4 phase-1 clock.
REQ-007 SHALL have port clk2  output  1  MCS-4 phase-2 clock.
REQ-008 SHALL have port sync  output  1  instruction-cycle marker.
REQ-009 SHALL have port poc  output  1  active-high power-on clear driven to downstream i4001/i4002 chips.
REQ-010 SHALL have port subcycle  output  3  current subcycle: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
REQ-011 SHALL have port cycle_start  output  1  one-sysclk pulse marking the first sysclk of A1.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 SHALL, in RUN, advance slot counter 0..SLOT_LEN-1, quarter 0..3 and subcycle 0..7 as a nested wrap-around count; one instruction cycle = 32*SLOT_LEN sysclk cycles (128 at default).
REQ-014 SHALL drive clk1 high exactly during quarter 0 and clk2 high exactly during quarter 2; quarters 1 and 3 keep both low; clk1 & clk2 never both high.
REQ-015 SHALL drive sync high during all four quarters of subcycle 7 (X3) and low otherwise.
REQ-016 SHALL drive clk1, clk2, sync, poc and cycle_start directly from flops. The flops are loaded from next-state decode, so the outputs change on the same edge as the counters, with no added lag and no glitches.
REQ-017 SHALL assert cycle_start for exactly the sysclk cycle where subcycle=0, quarter=0, slot=0.
REQ-018 SHALL sample run on the edge that would wrap X3 to A1:
  - run=1: continue with A1.
  - run=0: enter IDLE.
REQ-019 SHALL, in IDLE, hold clk1=clk2=sync=0, subcycle=0 and cycle_start=0, with all counters at zero.
REQ-020 SHALL move IDLE->RUN on the first edge sampling run=1; that edge drives clk1=1, subcycle=0 and cycle_start=1.
REQ-021 SHALL ignore a change of run in mid-cycle; a started instruction cycle always completes.
REQ-022 SHALL load a 4-bit poc counter with POC_CYCLES on reset, and decrement it on each X3->A1 or X3->IDLE transition while it is nonzero.
REQ-023 SHALL drive poc high while the poc counter is nonzero, and deassert it on the same edge the counter reaches zero.
REQ-024 SHALL not decrement the poc counter in IDLE.

Reset
REQ-025 SHALL, on any edge sampling poc_n=0, force state IDLE, all counters to 0, poc counter to POC_CYCLES, poc=1, and clk1=clk2=sync=cycle_start=0, subcycle=0. This applies also mid-cycle, including while clk1 or clk2 is high.
REQ-026 SHALL give reset priority over run and over every counter update.

Structure
REQ-027 SHALL take the subcycle encoding constants (A1..X3) and the FSM state encoding from the shared package mcs4_pkg, which is also used by timing_recovery consumers.
REQ-028 SHALL place the slot/quarter/subcycle nested counter in one sub-module, i4004_phase_ctr, with inputs enable and clear and outputs slot, quarter, subcycle and wrap.

Verification
REQ-029 SHALL cover default parameters with run=1 and poc_n released at edge N:
  - edge N+1: clk1=1, cycle_start=1, subcycle=0.
  - clk1 high 4 sysclk, then low 4; clk2 high 4, then low 4; period 16.
  - next cycle_start 128 sysclk later.
REQ-030 SHALL cover sync timing: sync rises 112 sysclk after cycle_start, with subcycle=7, stays high 16 sysclk, and falls coincident with the next cycle_start.
REQ-031 SHALL cover POC_CYCLES=4: poc=1 through 4 complete cycles, falling on the 5th cycle_start edge; a later run pause does not change poc.
REQ-032 SHALL cover run dropped at subcycle 3: the cycle completes through X3, then IDLE with all outputs 0; run=1 after 10 idle sysclks gives cycle_start on the next edge.
REQ-033 SHALL cover poc_n=0 asserted while clk2=1 at subcycle 5: next edge clk2=0, poc=1, subcycle=0, IDLE; the poc count restarts at 4.
REQ-034 SHALL cover SLOT_LEN=2: clk1 period 8 sysclk, instruction cycle 64 sysclk; an assertion checks that clk1&clk2 is never true for the whole run.
